// File: rtl/vga_pixel_fetch.sv
// Double-buffered VGA line fetcher: prefetches the next visible line into a ping-pong buffer and outputs RGB332 colour one cycle after the timing inputs.
// Optional test pattern (h XOR v colour) is enabled by defining VGA_PIXEL_FETCH_TEST_PATTERN_EN.
module vga_pixel_fetch #(
    parameter int h_res = 320,
    parameter int v_res = 480
) (
    input  logic        clk,
    input  logic        reset,
`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [8:0]  h_pixel,
    input  logic [9:0]  v_pixel,
    input  logic        h_sync,
    input  logic        v_sync,
    output logic [18:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        out_h_sync,
    output logic        out_v_sync,
    output logic        underrun
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t      state, state_next;
    logic [8:0]  x, x_next;
    logic [9:0]  target, target_next;
    logic [9:0]  v_prev;
    logic        prev_valid;
    logic [9:0]  last_target;
    logic        last_valid;
    logic        underrun_set;
    logic [10:0] v_inc;
    logic [9:0]  new_target;
    logic        trigger, accept, ack, last_ack;
    logic [18:0] fetch_addr;
    logic [7:0]  bank0 [h_res];
    logic [7:0]  bank1 [h_res];
    logic        visible;
    logic [8:0]  rd_idx;
    logic [7:0]  buf_byte, pixel_byte, colour_q;

    // The line after the last visible one wraps to 0, so blanking lines all map to the same target.
    assign v_inc      = {1'b0, v_pixel} + 11'd1;
    assign new_target = (int'(v_inc) < v_res) ? v_inc[9:0] : 10'd0;
    assign trigger    = prev_valid && (v_prev != v_pixel);
    assign accept     = trigger && (!last_valid || (new_target != last_target));
    assign ack        = (state == FETCH) && mem_ack;
    assign last_ack   = ack && (int'(x) == h_res - 1);
    assign fetch_addr = 19'(target) * 19'(h_res) + 19'(x);
    assign mem_req    = (state == FETCH);
    assign mem_addr   = (state == FETCH) ? fetch_addr : 19'd0;

    always_comb begin
        state_next   = state;
        x_next       = x;
        target_next  = target;
        underrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next  = FETCH;
                    x_next      = 9'd0;
                    target_next = new_target;
                end
            end
            FETCH: begin
                // A final ack in the same cycle as a new trigger counts as a completed line.
                if (accept) begin
                    x_next       = 9'd0;
                    target_next  = new_target;
                    underrun_set = !last_ack;
                end else if (last_ack) begin
                    state_next = IDLE;
                    x_next     = 9'd0;
                end else if (ack) begin
                    x_next = x + 9'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            x           <= 9'd0;
            target      <= 10'd0;
            v_prev      <= 10'd0;
            prev_valid  <= 1'b0;
            last_target <= 10'd0;
            last_valid  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state      <= state_next;
            x          <= x_next;
            target     <= target_next;
            v_prev     <= v_pixel;
            prev_valid <= 1'b1;
            if (accept) begin
                last_target <= new_target;
                last_valid  <= 1'b1;
            end
            if (underrun_set) underrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ack) begin
            if (target[0]) bank1[x] <= mem_data;
            else           bank0[x] <= mem_data;
        end
    end

    assign visible  = (int'(h_pixel) < h_res) && (int'(v_pixel) < v_res);
    assign rd_idx   = (int'(h_pixel) < h_res) ? h_pixel : 9'd0;
    assign buf_byte = v_pixel[0] ? bank1[rd_idx] : bank0[rd_idx];

`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
    assign pixel_byte = test_mode ? (h_pixel[7:0] ^ v_pixel[7:0]) : buf_byte;
`else
    assign pixel_byte = buf_byte;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            colour_q   <= 8'd0;
            out_h_sync <= 1'b0;
            out_v_sync <= 1'b0;
        end else begin
            colour_q   <= visible ? pixel_byte : 8'd0;
            out_h_sync <= h_sync;
            out_v_sync <= v_sync;
        end
    end

    assign red   = colour_q[7:5];
    assign green = colour_q[4:2];
    assign blue  = colour_q[1:0];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: line prefetch, handshake pacing, underrun, frame wrap and reset.
module tb_vga_pixel_fetch;

    localparam int h_res = 320;
    localparam int v_res = 480;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  h_pixel;
    logic [9:0]  v_pixel;
    logic        h_sync, v_sync;
    logic [18:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic        out_h_sync, out_v_sync;
    logic        underrun;
`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
    logic        test_mode;
`endif

    int checks = 0;
    int errors = 0;

    vga_pixel_fetch #(.h_res(h_res), .v_res(v_res)) dut (
        .clk(clk),
        .reset(reset),
`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .h_pixel(h_pixel),
        .v_pixel(v_pixel),
        .h_sync(h_sync),
        .v_sync(v_sync),
        .mem_addr(mem_addr),
        .mem_req(mem_req),
        .mem_ack(mem_ack),
        .mem_data(mem_data),
        .red(red),
        .green(green),
        .blue(blue),
        .out_h_sync(out_h_sync),
        .out_v_sync(out_v_sync),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pixel(input string tag, input logic [7:0] exp);
        check_output(tag, {24'd0, red, green, blue}, {24'd0, exp});
    endtask

    // Serves one whole line, acking every 'period' cycles; optionally moves v_pixel on the final ack.
    task automatic run_fetch(input int base, input int period, input logic [7:0] xorv,
                             input int next_v, input int next_addr);
        for (int i = 0; i < h_res; i++) begin
            for (int w = 0; w < period; w++) begin
                check_output("fetch_req", {31'd0, mem_req}, 32'd1);
                check_output("fetch_addr", {13'd0, mem_addr}, base + i);
                mem_ack  = (w == period - 1);
                mem_data = 8'(i) ^ xorv;
                if (w == period - 1 && i == h_res - 1 && next_v >= 0) v_pixel = next_v[9:0];
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
        if (next_v < 0) begin
            check_output("fetch_done_req", {31'd0, mem_req}, 32'd0);
        end else begin
            check_output("chain_req", {31'd0, mem_req}, 32'd1);
            check_output("chain_addr", {13'd0, mem_addr}, next_addr);
            check_output("chain_underrun", {31'd0, underrun}, 32'd0);
        end
    endtask

    initial begin
        logic [8:0] rb_h [4];
        logic [7:0] rb_b [4];
        rb_h = '{9'd0, 9'd1, 9'd100, 9'd319};
        rb_b = '{8'h5A, 8'h5B, 8'h3E, 8'h65};

        reset = 1'b0; h_pixel = 9'd0; v_pixel = 10'd4; h_sync = 1'b1; v_sync = 1'b1;
        mem_ack = 1'b0; mem_data = 8'd0;
`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        check_output("rst_req", {31'd0, mem_req}, 32'd0);
        check_output("rst_addr", {13'd0, mem_addr}, 32'd0);
        check_pixel("rst_colour", 8'h00);
        check_output("rst_syncs", {30'd0, out_h_sync, out_v_sync}, 32'd0);
        check_output("rst_underrun", {31'd0, underrun}, 32'd0);

        // Line 5 is being shown, so line 6 must be fetched: 6*320 = 1920.
        reset = 1'b1;
        @(negedge clk);
        v_pixel = 10'd5;
        @(negedge clk);
        run_fetch(1920, 1, 8'h00, -1, 0);

        for (int k = 0; k < 3; k++) begin
            mem_ack = 1'b1; mem_data = 8'hEE;
            @(negedge clk);
            check_output("idle_ack_req", {31'd0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;

        v_pixel = 10'd6; h_pixel = 9'd10; h_sync = 1'b1; v_sync = 1'b0;
        @(negedge clk);
        check_pixel("line6_h10", 8'h0A);
        check_output("sync_a", {30'd0, out_h_sync, out_v_sync}, 32'd2);
        h_pixel = 9'd0; h_sync = 1'b0; v_sync = 1'b1;
        @(negedge clk);
        check_pixel("line6_h0", 8'h00);
        check_output("sync_b", {30'd0, out_h_sync, out_v_sync}, 32'd1);
        h_pixel = 9'd255;
        @(negedge clk);
        check_pixel("line6_h255", 8'hFF);
        h_pixel = 9'd320;
        @(negedge clk);
        check_pixel("h_blank", 8'h00);

        // Line 7 at 2240 with slow acks; v_pixel moves to 7 on the final ack, so line 8 follows at 2560.
        run_fetch(2240, 3, 8'h5A, 7, 2560);

        for (int k = 0; k < 4; k++) begin
            h_pixel = rb_h[k];
            @(negedge clk);
            check_pixel("line7_readback", rb_b[k]);
        end

        for (int k = 0; k < 5; k++) begin
            check_output("part_addr", {13'd0, mem_addr}, 2560 + k);
            mem_ack = 1'b1; mem_data = 8'h11;
            @(negedge clk);
        end
        check_output("part_addr_end", {13'd0, mem_addr}, 2565);
        mem_ack = 1'b0; v_pixel = 10'd8;
        @(negedge clk);
        check_output("abort_underrun", {31'd0, underrun}, 32'd1);
        check_output("abort_req", {31'd0, mem_req}, 32'd1);
        check_output("abort_addr", {13'd0, mem_addr}, 2880);
        repeat (3) @(negedge clk);
        check_output("underrun_sticky", {31'd0, underrun}, 32'd1);

        // Last visible line wraps the target to line 0; blanking lines must not refetch it.
        v_pixel = 10'd479;
        @(negedge clk);
        run_fetch(0, 1, 8'hC3, -1, 0);
        for (int v = 480; v <= 524; v++) begin
            v_pixel = 10'(v); h_pixel = 9'd5;
            @(negedge clk);
            check_output("blank_req", {31'd0, mem_req}, 32'd0);
            check_pixel("v_blank", 8'h00);
        end
        v_pixel = 10'd0; h_pixel = 9'd5;
        @(negedge clk);
        check_output("wrap_req", {31'd0, mem_req}, 32'd1);
        check_output("wrap_addr", {13'd0, mem_addr}, 320);
        check_pixel("line0_h5", 8'hC6);
        h_pixel = 9'd6; h_sync = 1'b1; v_sync = 1'b1;
        @(negedge clk);
        check_pixel("line0_h6", 8'hC5);
        check_output("sync_c", {30'd0, out_h_sync, out_v_sync}, 32'd3);

        reset = 1'b0;
        #1;
        check_output("async_rst_req", {31'd0, mem_req}, 32'd0);
        check_output("async_rst_addr", {13'd0, mem_addr}, 32'd0);
        check_pixel("async_rst_colour", 8'h00);
        check_output("async_rst_syncs", {30'd0, out_h_sync, out_v_sync}, 32'd0);
        check_output("async_rst_underrun", {31'd0, underrun}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("post_rst_idle", {31'd0, mem_req}, 32'd0);
        v_pixel = 10'd1;
        @(negedge clk);
        check_output("post_rst_req", {31'd0, mem_req}, 32'd1);
        check_output("post_rst_addr", {13'd0, mem_addr}, 640);
        check_output("post_rst_underrun", {31'd0, underrun}, 32'd0);

`ifdef VGA_PIXEL_FETCH_TEST_PATTERN_EN
        test_mode = 1'b1; h_pixel = 9'h0F; v_pixel = 10'h0F0;
        @(negedge clk);
        check_pixel("pattern_ff", 8'hFF);
        h_pixel = 9'h01;
        @(negedge clk);
        check_pixel("pattern_f1", 8'hF1);
        test_mode = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameter h_res, default 320, meaning visible pixels per line.
REQ-002 SHALL have parameter v_res, default 480, meaning visible lines per frame.
REQ-003 SHALL have port clk  input  1  the only clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port h_pixel  input  9  column from the timing generator.
REQ-006 SHALL have port v_pixel  input  10  line from the timing generator.
REQ-007 SHALL have ports h_sync, v_sync  input  1 each  syncs from the timing generator.
REQ-008 SHALL have port mem_addr  output  19  framebuffer byte address.
REQ-009 SHALL have port mem_req  output  1  read request.
REQ-010 SHALL have port mem_ack  input  1  read accepted; mem_data valid this cycle.
REQ-011 SHALL have port mem_data  input  8  pixel byte, RGB332.
REQ-012 SHALL have ports red, green, blue  output  3/3/2  pixel colour.
REQ-013 SHALL have ports out_h_sync, out_v_sync  output  1 each  syncs delayed to align with colour.
REQ-014 SHALL have port underrun  output  1  sticky fetch-overrun flag.

Function
REQ-015 SHALL hold two line buffers (banks 0/1) of h_res bytes each; line L is stored in bank L[0].
REQ-016 Pixel is visible iff h_pixel < h_res and v_pixel < v_res; otherwise colour SHALL be 0.
REQ-017 Visible colour SHALL be byte h_pixel of bank v_pixel[0], split as {red,green,blue} = byte[7:5],[4:2],[1:0].
REQ-018 Colour and out_*_sync SHALL appear exactly 1 cycle after the corresponding h_pixel/v_pixel/sync inputs.
REQ-019 Fetch trigger: registered v_pixel differs from current v_pixel; target = v_pixel+1 if v_pixel+1 < v_res, else 0.
REQ-020 A trigger SHALL start a fetch only if target differs from the last-started target (blanking lines do not refetch line 0).
REQ-021 FSM states: IDLE, FETCH; IDLE->FETCH on accepted trigger, FETCH->IDLE after the byte at x = h_res-1 is acked.
REQ-022 In FETCH, mem_req SHALL be 1 with mem_addr = target*h_res + x held stable until mem_ack = 1.
REQ-023 On mem_ack, mem_data SHALL be written to bank target[0] at x, and x SHALL increment the next cycle; mem_req may remain high.
REQ-024 mem_ack while mem_req = 0 SHALL be ignored.
REQ-025 An accepted trigger during FETCH SHALL abort the fetch, set underrun = 1, and restart at x = 0 for the new target the next cycle.
REQ-026 Trigger and final ack in the same cycle: ack completes the old fetch, then the new fetch starts (no underrun).
REQ-027 Address arithmetic SHALL be 19-bit unsigned, no truncation for h_res*v_res <= 2^19.

Reset
REQ-028 On reset low: state IDLE, x = 0, mem_req = 0, mem_addr = 0, colour = 0, out syncs = 0, underrun = 0, last target = invalid (first trigger always accepted).
REQ-029 Reset mid-fetch SHALL drop mem_req immediately (asynchronously); line buffer contents are undefined after reset.
REQ-030 underrun SHALL clear only by reset.

Configuration
REQ-031 Macro VGA_PIXEL_FETCH_TEST_PATTERN_EN defined: add input test_mode (1 bit); when 1, visible colour SHALL be h_pixel[7:0] XOR v_pixel[7:0] (same split/latency), and fetches still run.
REQ-032 Macro undefined: no test_mode port and colour always from the line buffer.

Verification
REQ-033 Reset low mid-fetch -> mem_req 0 same cycle, all outputs 0; after release, the first v_pixel change issues a fetch at the target's address.
REQ-034 v_pixel 4->5, ack every cycle, mem_data = x[7:0] -> addresses 1920..2239 requested; on line 6, h_pixel = 10 gives {red,green,blue} = 3'b000/3'b010/2'b10 one cycle later.
REQ-035 Ack every 3rd cycle: mem_addr stable until ack; exactly 320 writes; no skipped or duplicated x.
REQ-036 v_pixel changes again before the fetch completes -> underrun = 1 and stays 1; new fetch restarts at target*320.
REQ-037 v_pixel 479->480..524->0 -> a single fetch of line 0 (addresses 0..319); h_pixel >= 320 or v_pixel >= 480 gives colour 0.
REQ-038 With VGA_PIXEL_FETCH_TEST_PATTERN_EN and test_mode = 1, h_pixel = 0x0F, v_pixel = 0xF0 -> colour byte 0xFF one cycle later.
